// File: rtl/mc_traffic_checker.sv
// mc_traffic_checker: parametrised request generator and in-order read-data checker for memory_controller
module mc_traffic_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 200,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [COUNT_WIDTH-1:0] num_req,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   data_pat,
  input  logic                   out_busy,
  output logic                   in_valid,
  output logic                   in_request_type,
  output logic [ADDR_WIDTH-1:0]  in_request_address,
  output logic [DATA_WIDTH-1:0]  in_request_data,
  input  logic                   write_done,
  input  logic                   read_done,
  input  logic [DATA_WIDTH-1:0]  data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] first_err_idx,
  output logic [31:0]            cycle_count
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  function automatic logic [DATA_WIDTH-1:0] lfsr_nx(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1] ^ v[DATA_WIDTH-3] ^ v[DATA_WIDTH-4] ^ v[DATA_WIDTH-6]};
  endfunction
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d, idx_q, idx_d, cidx_q, cidx_d, rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d, ferr_q, ferr_d, nidx;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, wlfsr_q, wlfsr_d, clfsr_q, clfsr_d, exp_data;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0] cyc_q, cyc_d;
  logic pat_q, pat_d, vld_q, vld_d, typ_q, typ_d, tmo_q, tmo_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic fire, ld, last, spur, bad;
  assign fire = vld_q && !out_busy;
  assign ld = (state_q == WRITE || state_q == READ) && (!vld_q || !out_busy);
  assign nidx = idx_q + 1'b1;
  assign last = nidx == num_q;
  assign exp_data = pat_q ? clfsr_q : DATA_WIDTH'(cidx_q);
  assign spur = read_done && rd_out_q == '0;
  assign bad = read_done && (spur || data_out != exp_data);
  // next-state: request issue, outstanding tracking, read checking, drain/timeout and run launch
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    num_d = num_q;
    base_d = base_q;
    pat_d = pat_q;
    idx_d = idx_q;
    addr_d = addr_q;
    typ_d = typ_q;
    wdat_d = wdat_q;
    wlfsr_d = wlfsr_q;
    clfsr_d = clfsr_q;
    cidx_d = cidx_q;
    idle_d = idle_q;
    tmo_d = tmo_q;
    err_d = err_q;
    ferr_d = ferr_q;
    vld_d = vld_q && out_busy;
    rd_out_d = rd_out_q + COUNT_WIDTH'(fire && !typ_q) - COUNT_WIDTH'(read_done && !spur);
    wr_out_d = wr_out_q + COUNT_WIDTH'(fire && typ_q) - COUNT_WIDTH'(write_done && wr_out_q != '0);
    cyc_d = busy_q && !(&cyc_q) ? cyc_q + 1'b1 : cyc_q;
    if (read_done && !spur) begin
      cidx_d = cidx_q + 1'b1;
      clfsr_d = lfsr_nx(clfsr_q);
    end
    if (bad) begin
      err_d = &err_q ? err_q : err_q + 1'b1;
      ferr_d = err_q == '0 ? cidx_q : ferr_q;
    end
    if (ld) begin
      vld_d = 1'b1;
      typ_d = state_q == WRITE;
      addr_d = base_q + ADDR_WIDTH'(idx_q);
      wdat_d = pat_q ? wlfsr_q : DATA_WIDTH'(idx_q);
      if (state_q == WRITE) begin
        wlfsr_d = lfsr_nx(wlfsr_q);
        idx_d = mode_q == 2'd1 ? idx_q : (last ? '0 : nidx);
        state_d = mode_q == 2'd1 ? READ : (!last ? WRITE : (mode_q == 2'd0 ? READ : DRAIN));
      end else begin
        idx_d = nidx;
        state_d = last ? DRAIN : (mode_q == 2'd1 ? WRITE : READ);
      end
    end
    if (state_q == DRAIN) begin
      if (!vld_q && rd_out_q == '0 && wr_out_q == '0) state_d = DONE;
      else if (read_done || write_done) idle_d = '0;
      else begin
        idle_d = idle_q + 1'b1;
        if (idle_d == TMO) begin
          tmo_d = 1'b1;
          state_d = DONE;
        end
      end
    end
    if (start && (state_q == IDLE || state_q == DONE)) begin
      mode_d = mode;
      num_d = num_req;
      base_d = base_addr;
      pat_d = data_pat;
      idx_d = '0;
      cidx_d = '0;
      wlfsr_d = LFSR_SEED;
      clfsr_d = LFSR_SEED;
      rd_out_d = '0;
      wr_out_d = '0;
      idle_d = '0;
      tmo_d = 1'b0;
      err_d = '0;
      ferr_d = '1;
      cyc_d = '0;
      vld_d = 1'b0;
      state_d = num_req == '0 ? DONE : (mode == 2'd3 ? READ : WRITE);
    end
    busy_d = state_d == WRITE || state_d == READ || state_d == DRAIN;
    done_d = state_d == DONE;
    pass_d = done_d && err_d == '0 && !tmo_d;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      num_q <= '0;
      base_q <= '0;
      pat_q <= 1'b0;
      idx_q <= '0;
      addr_q <= '0;
      typ_q <= 1'b0;
      wdat_q <= '0;
      wlfsr_q <= LFSR_SEED;
      clfsr_q <= LFSR_SEED;
      cidx_q <= '0;
      rd_out_q <= '0;
      wr_out_q <= '0;
      idle_q <= '0;
      tmo_q <= 1'b0;
      err_q <= '0;
      ferr_q <= '1;
      cyc_q <= '0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      num_q <= num_d;
      base_q <= base_d;
      pat_q <= pat_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      typ_q <= typ_d;
      wdat_q <= wdat_d;
      wlfsr_q <= wlfsr_d;
      clfsr_q <= clfsr_d;
      cidx_q <= cidx_d;
      rd_out_q <= rd_out_d;
      wr_out_q <= wr_out_d;
      idle_q <= idle_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      ferr_q <= ferr_d;
      cyc_q <= cyc_d;
      vld_q <= vld_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign in_valid = vld_q;
  assign in_request_type = typ_q;
  assign in_request_address = addr_q;
  assign in_request_data = wdat_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = tmo_q;
  assign error_count = err_q;
  assign first_err_idx = ferr_q;
  assign cycle_count = cyc_q;
endmodule

// File: doc/mc_traffic_checker.md
Name: mc_traffic_checker

Overview:
- Synthesizable, emulation-ready request generator and read-data checker for memory_controller.
- Replaces the fixed 1023-write/1023-read bench loop with a parametrised engine:
  - run-time request count, base address, traffic mode and data pattern;
  - in-order read checking, error and timeout reporting;
  - cycle counting.
- Sits between a control/status host (or bench) and the memory_controller request port.

Parameters:
- DATA_WIDTH, 16, width of request data and returned read data.
- ADDR_WIDTH, 30, width of request address.
- COUNT_WIDTH, 16, width of request count, indices and error counter.
- TIMEOUT_CYCLES, 200, idle cycles allowed in DRAIN before declaring timeout.
- LFSR_SEED, 16'hACE1, non-zero seed for the pseudo-random data pattern (DATA_WIDTH bits).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a run with the current config inputs.
- mode  in  2  traffic mode; sampled on start:
  - 0 = write-all then read-all;
  - 1 = interleaved W(i),R(i);
  - 2 = write-only;
  - 3 = read-only.
- num_req  in  COUNT_WIDTH  addresses per run; sampled on start.
- base_addr  in  ADDR_WIDTH  first address; sampled on start.
- data_pat  in  1  data pattern; sampled on start:
  - 0 = data is idx[DATA_WIDTH-1:0];
  - 1 = Fibonacci LFSR sequence.
- out_busy  in  1  controller cannot accept a request this cycle.
- in_valid  out  1  request valid.
- in_request_type  out  1  1 = write, 0 = read.
- in_request_address  out  ADDR_WIDTH  request address.
- in_request_data  out  DATA_WIDTH  write data.
- write_done  in  1  one write completed.
- read_done  in  1  one read returned; data_out is valid.
- data_out  in  DATA_WIDTH  read data.
- busy  out  1  run in progress.
- done  out  1  run finished; level, held until next start or rst.
- pass  out  1  valid when done; 1 = no errors and no timeout.
- timeout  out  1  DRAIN idle limit hit.
- error_count  out  COUNT_WIDTH  mismatches plus spurious read_done; saturating.
- first_err_idx  out  COUNT_WIDTH  read index of first error.
- cycle_count  out  32  cycles from start acceptance to DONE entry; saturating.

Behaviour:
- Reset values:
  - All outputs 0, except first_err_idx, which resets to all-ones.
  - FSM in IDLE; LFSRs reseeded.
- rst mid-run aborts immediately: in_valid is 0 from the next edge, and no completion is reported.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - start is accepted only in IDLE or DONE; it is ignored while busy.
  - On acceptance: clear counters, status and cycle_count; then go to:
    - mode 0 or 2: WRITE;
    - mode 1: WRITE;
    - mode 3: READ.
  - num_req == 0: go to DONE next cycle with pass = 1.
- Handshake:
  - A request transfers on any edge where in_valid = 1 and out_busy = 0.
  - All request outputs are registered and held stable while out_busy = 1.
  - Back-to-back transfers are allowed, one per cycle.
- Address: base_addr + idx, modulo 2^ADDR_WIDTH (wrap-around is legal).
- Mode 0: issue writes idx 0..num_req-1, then reads idx 0..num_req-1, then DRAIN.
- Mode 1: alternate W(idx), R(idx) for each idx, then DRAIN.
- Mode 2: writes only, then DRAIN.
- Mode 3: reads only, then DRAIN.
- Write data and expected read data come from separate generators with identical sequences:
  - the write generator advances per accepted write;
  - the check generator advances per read_done.
  - This makes read results order-checked against write order.
- Outstanding counters:
  - rd_out: +1 per accepted read, -1 per read_done; both in the same cycle leaves it unchanged.
  - wr_out: tracked the same way with write_done.
- Errors:
  - A read_done with data_out != expected increments error_count.
  - A read_done while rd_out == 0 is spurious: it increments error_count and the check generator does not advance.
  - first_err_idx captures the check index on the first error only.
  - error_count saturates at all-ones.
- DRAIN:
  - Exit to DONE when rd_out == 0 and wr_out == 0.
  - Idle counter resets on any read_done or write_done.
  - If the idle counter reaches TIMEOUT_CYCLES: set timeout = 1 and go to DONE.
- DONE:
  - busy = 0, done = 1.
  - pass = (error_count == 0) and !timeout.
  - Responses that arrive late are still checked, and may raise error_count.
- cycle_count increments every cycle while busy.

Test Plan:
1. mode=0, num_req=1023, base_addr=0, data_pat=0, out_busy=0, ideal memory → 2046 transfers; done=1, pass=1, error_count=0.
2. mode=1, num_req=16, data_pat=1, out_busy toggled every 3 cycles → request outputs stable while busy, in order W0,R0..W15,R15; pass=1.
3. Memory corrupts read of idx 5 (data_out bit0 flipped), mode=0, num_req=8 → error_count=1, first_err_idx=5, pass=0.
4. Memory drops the last read_done, mode=3, num_req=4 → DONE 200 cycles after the last response; timeout=1, pass=0.
5. base_addr=2^30-2, num_req=4, mode=2 → addresses 3FFFFFFE, 3FFFFFFF, 0, 1.
6. rst asserted mid-WRITE, then start with num_req=0 → in_valid=0 after one edge, all outputs reset; next start gives done=1, pass=1 one cycle later.
